// File: rtl/popcount_sched_pkg.sv
// Shared types and constants for the popcount_sched engine.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, default NREQ/WIDTH/CHUNK, cnt_w() count-width helper.
package popcount_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHUNK = 2;

  // Bits needed to hold a count from 0 up to and including width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/popcount_chunk_acc.sv
// Counts the bits of one CHUNK-wide slice that match i_what and accumulates them.
// Latency: combinational chunk count, registered sum one edge after i_en.
// Backpressure: none; the owner FSM decides when to clear (i_clr) or add (i_en).
// Ports: clk, rst_n (async active-low); i_clr zeroes the sum (priority over i_en);
//        i_en adds the count of i_chunk bits equal to i_what; o_acc is the running sum.
module popcount_chunk_acc #(
  parameter int CHUNK = 2,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CHUNK-1:0] i_chunk,
  input  logic             i_what,
  output logic [CW-1:0]    o_acc
);

  logic [CW-1:0] w_hits;
  logic [CW-1:0] r_acc;

  // Case equality: an X or Z bit never matches a 0/1 "what".
  always_comb begin
    w_hits = '0;
    for (int b = 0; b < CHUNK; b++) begin
      if (i_chunk[b] === i_what) begin
        w_hits = w_hits + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_hits;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/popcount_sched.sv
// Shared multi-cycle bit-match counter with a round-robin front end over NREQ requesters.
// Latency: rsp_valid rises WIDTH/CHUNK edges after the accept edge (1..WIDTH/CHUNK with early exit).
// Backpressure: result held in DONE until rsp_ready; no new request is accepted until then.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_value/req_what per requester
//        (req_ready is a one-hot grant, IDLE only); rsp_valid/rsp_ready/rsp_id/rsp_count result.
// Build option: define POPCOUNT_SCHED_EARLY_EXIT_EN to stop scanning once no higher bit can match.
module popcount_sched
  import popcount_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*WIDTH-1:0]       req_value,
  input  logic [NREQ-1:0]             req_what,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NREQ)-1:0]     rsp_id,
  output logic [cnt_w(WIDTH)-1:0]     rsp_count
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = $clog2(NREQ);
  localparam int CW  = cnt_w(WIDTH);
  localparam int XW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("popcount_sched: WIDTH must be a multiple of CHUNK");
  end
  if (NREQ < 2) begin : g_bad_nreq
    $error("popcount_sched: NREQ must be at least 2");
  end

  state_t           r_state;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    r_id;
  logic [WIDTH-1:0] r_value;
  logic             r_what;
  logic [XW-1:0]    r_idx;
  logic             r_rsp_vld;

  logic             w_found;
  logic [IW-1:0]    w_gnt;
  logic             w_accept;
  logic             w_last_chunk;
  logic             w_scan_end;
  logic [CHUNK-1:0] w_chunk;
  logic [CW-1:0]    w_acc;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req_valid[IW'((int'(r_last) + k) % NREQ)]) begin
        w_found = 1'b1;
        w_gnt   = IW'((int'(r_last) + k) % NREQ);
      end
    end
  end

  assign w_accept = (r_state == IDLE) && w_found;

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_gnt] = 1'b1;
    end
  end

  assign w_chunk      = r_value[int'(r_idx)*CHUNK +: CHUNK];
  assign w_last_chunk = (r_idx == XW'(NCH - 1));

`ifdef POPCOUNT_SCHED_EARLY_EXIT_EN
  logic w_rest_hit;

  // Any matching bit strictly above the chunk being added this cycle?
  always_comb begin
    w_rest_hit = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      if ((b >= (int'(r_idx) + 1) * CHUNK) && (r_value[b] === r_what)) begin
        w_rest_hit = 1'b1;
      end
    end
  end

  assign w_scan_end = w_last_chunk || !w_rest_hit;
`else
  assign w_scan_end = w_last_chunk;
`endif

  popcount_chunk_acc #(
    .CHUNK (CHUNK),
    .CW    (CW)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_accept),
    .i_en    (r_state == SCAN),
    .i_chunk (w_chunk),
    .i_what  (r_what),
    .o_acc   (w_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= IW'(NREQ - 1);
      r_id      <= '0;
      r_value   <= '0;
      r_what    <= 1'b0;
      r_idx     <= '0;
      r_rsp_vld <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_value <= req_value[int'(w_gnt)*WIDTH +: WIDTH];
            r_what  <= req_what[w_gnt];
            r_id    <= w_gnt;
            r_idx   <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_scan_end) begin
            r_rsp_vld <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_idx <= r_idx + XW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_last    <= r_id;
            r_rsp_vld <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_rsp_vld <= 1'b0;
        end
      endcase
    end
  end

  // The accumulator is frozen outside SCAN, so it doubles as the held result.
  assign rsp_valid = r_rsp_vld;
  assign rsp_id    = r_id;
  assign rsp_count = w_acc;

endmodule

// File: tb/tb_popcount_sched.sv
module tb_popcount_sched;
  import popcount_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CHUNK = 2;

`ifdef POPCOUNT_SCHED_EARLY_EXIT_EN
  localparam int LAT_ZERO = 1;
  localparam int LAT_FIX  = -1;
`else
  localparam int LAT_ZERO = 4;
  localparam int LAT_FIX  = 4;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_value;
  logic [NREQ-1:0]       req_what;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [3:0]            rsp_count;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] xval;

  always #5 clk = ~clk;

  popcount_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_value (req_value),
    .req_what  (req_what),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input int cnt);
    exp_t e;
    e.id  = 2'(id);
    e.cnt = 4'(cnt);
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every response handshake is popped and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual_id=%0d actual_count=%0d expected=none", rsp_id, rsp_count);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_count", 32'(rsp_count), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Wait for rsp_valid, sampled 1 time unit after each rising edge.
  task automatic wait_rsp(input string name);
    bit got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_rsp_timeout actual=no_rsp required=rsp_valid", name);
    end
  endtask

  // Issue one request, push its expectation at grant, measure latency to rsp_valid.
  task automatic send(input int id, input logic [7:0] val, input logic what,
                      input int exp_cnt, input int exp_lat);
    bit got = 0;
    int lat = 0;
    @(posedge clk); #1;
    req_value[id*WIDTH +: WIDTH] = val;
    req_what[id]  = what;
    req_valid[id] = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready[id] === 1'b1) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout_req%0d actual=no_grant required=grant", id);
      req_valid[id] = 1'b0;
      return;
    end
    chk($sformatf("grant_onehot_req%0d", id), 32'(req_ready), 32'(1 << id));
    push_exp(id, exp_cnt);
    @(posedge clk); #1;
    // Changing inputs after accept must not disturb the result.
    req_valid[id] = 1'b0;
    req_value[id*WIDTH +: WIDTH] = ~val;
    req_what[id]  = ~what;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid === 1'b1) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout_req%0d actual=no_rsp required=rsp_valid", id);
    end else if (exp_lat > 0) begin
      chk($sformatf("latency_req%0d", id), 32'(lat), 32'(exp_lat));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_value = '0;
    req_what  = '0;
    rsp_ready = 1'b1;
    xval      = 8'b1x1z_0000;

    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_count", 32'(rsp_count), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    chk("idle_req_ready", 32'(req_ready), 0);

    // Directed single requests
    send(0, 8'h00, 1'b1, 0, LAT_ZERO); @(posedge clk); #1;
    send(1, 8'h3C, 1'b1, 4, LAT_FIX);  @(posedge clk); #1;
    send(1, 8'hBD, 1'b1, 6, LAT_FIX);  @(posedge clk); #1;
    send(1, 8'hBD, 1'b0, 2, LAT_FIX);  @(posedge clk); #1;
    send(1, 8'hFF, 1'b1, 8, LAT_FIX);  @(posedge clk); #1;
    // X/Z bits never count; served by req3 so round robin restarts at req0
    send(3, xval, 1'b1, 2, LAT_FIX);   @(posedge clk); #1;

    // All requesters valid: grants 0,1,2,3,0
    req_value = {8'h7F, 8'hE0, 8'h0F, 8'h01};
    req_what  = 4'b1011;
    req_valid = 4'b1111;
    push_exp(0, 1); push_exp(1, 4); push_exp(2, 5); push_exp(3, 7); push_exp(0, 1);
    for (int r = 0; r < 5; r++) begin
      wait_rsp("rr");
      @(posedge clk); #1;
    end
    req_valid = '0;

    // Consumer stall with a pending requester
    rsp_ready = 1'b0;
    send(3, 8'h81, 1'b1, 2, LAT_FIX);
    req_value[0 +: WIDTH] = 8'h55;
    req_what[0]  = 1'b0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", 32'(rsp_valid), 1);
      chk("stall_rsp_id", 32'(rsp_id), 3);
      chk("stall_rsp_count", 32'(rsp_count), 2);
      chk("stall_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_cycle_req_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    chk("post_hs_grant", 32'(req_ready), 32'h1);
    push_exp(0, 4);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp("post_stall");
    @(posedge clk); #1;

    // Reset during SCAN of req2
    req_value[2*WIDTH +: WIDTH] = 8'hFF;
    req_what[2]  = 1'b1;
    req_valid[2] = 1'b1;
    @(negedge clk);
    chk("rst_test_grant_req2", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_rsp_count", 32'(rsp_count), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_value = {8'hAA, 8'hFF, 8'h33, 8'h0F};
    req_what  = 4'b1111;
    req_valid = 4'b1111;
    #1;
    chk("after_rst_first_grant", 32'(req_ready), 32'h1);
    push_exp(0, 4);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp("after_rst");
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
